// File: rtl/tqvp_bus_pkg.sv
// Shared size codes, FSM state type and read-data masking for the TinyQV bus initiator.
package tqvp_bus_pkg;

    localparam logic [1:0] SZ_8    = 2'b00;
    localparam logic [1:0] SZ_16   = 2'b01;
    localparam logic [1:0] SZ_32   = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_8:    size_mask = 32'h0000_00ff;
            SZ_16:   size_mask = 32'h0000_ffff;
            default: size_mask = 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/tqvp_bus_initiator_if.sv
// TinyQV peripheral-side bus: the initiator drives address/data/strobes, the peripheral answers.
interface tqvp_bus_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] per_address;
    logic [31:0]       per_data_in;
    logic [1:0]        per_data_write_n;
    logic [1:0]        per_data_read_n;
    logic [31:0]       per_data_out;
    logic              per_data_ready;
    logic              per_user_interrupt;

    modport master (
        output per_address, per_data_in, per_data_write_n, per_data_read_n,
        input  per_data_out, per_data_ready, per_user_interrupt
    );

    modport slave (
        input  per_address, per_data_in, per_data_write_n, per_data_read_n,
        output per_data_out, per_data_ready, per_user_interrupt
    );
endinterface

// File: rtl/tqvp_irq_edge_latch.sv
// Registers the peripheral interrupt and keeps a sticky flag of its rising edges.
module tqvp_irq_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    input  logic irq_clear,
    output logic irq_seen
);
    logic irq_sync;
    logic irq_prev;
    logic irq_rise;

    assign irq_rise = irq_sync & ~irq_prev;

    // set has priority so an edge coinciding with a clear is never lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_sync <= 1'b0;
            irq_prev <= 1'b0;
            irq_seen <= 1'b0;
        end else begin
            irq_sync <= irq_in;
            irq_prev <= irq_sync;
            if (irq_rise)
                irq_seen <= 1'b1;
            else if (irq_clear)
                irq_seen <= 1'b0;
        end
    end
endmodule

// File: rtl/tqvp_bus_initiator.sv
// Single-command initiator for the TinyQV peripheral bus, used as a bring-up host.
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   WRITE | write strobe on the bus for one cycle
//   READ  | read strobe held until data_ready or timeout
//   RESP  | rsp_valid high until rsp_ready
module tqvp_bus_initiator
    import tqvp_bus_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    tqvp_bus_if.master        bus,
    output logic              irq_seen,
    input  logic              irq_clear
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_d;
    logic [1:0]        size_q, size_d;
    logic [7:0]        cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        wr_n_q, wr_n_d;
    logic [1:0]        rd_n_q, rd_n_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    assign cmd_ready            = (state == IDLE);
    assign rsp_valid            = (state == RESP);
    assign rsp_rdata            = rdata_q;
    assign rsp_err              = err_q;
    assign bus.per_address      = addr_q;
    assign bus.per_data_in      = wdata_q;
    assign bus.per_data_write_n = wr_n_q;
    assign bus.per_data_read_n  = rd_n_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            size_q  <= SZ_NONE;
            cnt     <= 8'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            wr_n_q  <= SZ_NONE;
            rd_n_q  <= SZ_NONE;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            size_q  <= size_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_n_q  <= wr_n_d;
            rd_n_q  <= rd_n_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // strobes default back to idle; each state re-asserts them only while needed
    always_comb begin
        state_d = state;
        size_d  = size_q;
        cnt_d   = cnt;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_n_d  = SZ_NONE;
        rd_n_d  = SZ_NONE;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    size_d  = cmd_size;
                    if (cmd_size == SZ_NONE) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (cmd_write) begin
                        state_d = WRITE;
                        wr_n_d  = cmd_size;
                    end else begin
                        state_d = READ;
                        rd_n_d  = cmd_size;
                        cnt_d   = 8'd0;
                    end
                end
            end
            WRITE: begin
                state_d = RESP;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
            READ: begin
                if (bus.per_data_ready) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = bus.per_data_out & size_mask(size_q);
                end else if (cnt == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d  = cnt + 8'd1;
                    rd_n_d = size_q;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    tqvp_irq_edge_latch u_irq (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (bus.per_user_interrupt),
        .irq_clear (irq_clear),
        .irq_seen  (irq_seen)
    );
endmodule

// File: doc/tqvp_bus_initiator.md
Name: tqvp_bus_initiator

Overview:
Initiator side of the TinyQV peripheral bus. It accepts single read/write commands over a valid/ready port and drives the peripheral-side signals (address, data_in, data_write_n, data_read_n). It waits for data_ready on reads and returns masked read data or an error over a valid/ready response port. It is used as a bring-up and verification host for peripherals such as the watchdog, and also latches the peripheral's user_interrupt.

Parameters:
TIMEOUT, 16, maximum cycles a read waits for per_data_ready before an error response; legal range 1..255
ADDR_W, 6, peripheral address width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_size  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
cmd_addr  in  ADDR_W  target register address
cmd_wdata  in  32  write data
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  32  read data, zero-extended per size; 0 for writes and errors
rsp_err  out  1  1 = timeout or illegal size
per_address  out  ADDR_W  peripheral address
per_data_in  out  32  peripheral write data
per_data_write_n  out  2  11 = idle, else size code
per_data_read_n  out  2  11 = idle, else size code
per_data_out  in  32  peripheral read data
per_data_ready  in  1  peripheral read data valid (may be combinational from per_data_read_n)
per_user_interrupt  in  1  peripheral interrupt level
irq_seen  out  1  sticky: interrupt rose since last clear
irq_clear  in  1  clears irq_seen

Behaviour:
- Reset values (synchronous, rst_n low at posedge):
  - state = IDLE; cmd_ready = 1; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - per_data_write_n = per_data_read_n = 11; per_address = 0; per_data_in = 0.
  - irq_seen = 0; irq edge register = 0; timeout counter = 0.
- All bus outputs are registered. Reset asserted mid-transaction aborts it: bus strobes return to 11 on that edge, and no response is issued.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: cmd_ready = 1.
  - On handshake, latch cmd_addr, cmd_size and cmd_wdata. Next cycle, per_address and per_data_in reflect the latched values.
  - cmd_size == 11: go to RESP with rsp_err = 1 and rsp_rdata = 0. No bus strobe is issued.
  - Write: go to WRITE. per_data_write_n = cmd_size for exactly one cycle.
  - Read: go to READ. per_data_read_n = cmd_size; timeout counter cleared.
- WRITE: lasts one cycle. Next edge: strobe returns to 11, go to RESP with rsp_err = 0 and rsp_rdata = 0. per_data_ready is ignored for writes.
- READ: per_data_read_n is held at the size code every cycle.
  - If per_data_ready is high in a cycle, capture per_data_out masked by size on that edge: 8-bit keeps [7:0], 16-bit keeps [15:0], 32-bit keeps all bits. Upper bits are zeroed. rsp_err = 0; strobe returns to 11; go to RESP.
  - If per_data_ready is high in the first READ cycle, the response is valid on the following cycle (minimum read latency 2 cycles from command acceptance to rsp_valid).
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT-1 without per_data_ready: rsp_err = 1, rsp_rdata = 0, strobe returns to 11, go to RESP.
  - per_data_ready in the same cycle as the timeout wins (data is returned, no error).
- RESP: rsp_valid = 1, with rsp_rdata and rsp_err stable until the handshake. On handshake go to IDLE. cmd_ready = 0 throughout WRITE, READ and RESP, so there is no back-to-back overlap.
- Address and data are held stable on the bus from the cycle after acceptance through RESP. They keep their last value in IDLE.
- IRQ capture: per_user_interrupt is registered.
  - A rising edge (registered 0 -> current 1) sets irq_seen.
  - irq_clear clears it. A simultaneous rising edge and irq_clear leaves irq_seen = 1 (set wins).
  - A level held high does not re-set irq_seen after a clear.

Decomposition:
- Package tqvp_bus_pkg:
  - size codes SZ_8 = 2'b00, SZ_16 = 2'b01, SZ_32 = 2'b10, SZ_NONE = 2'b11.
  - FSM state enum.
  - function size_mask(size) returning the 32-bit mask.
- Optional sub-module tqvp_irq_edge_latch for the interrupt register, edge detect and sticky bit. Everything else stays in one module.

Test Plan:
- Write 32-bit 0x0000_0010 to addr 2, rsp_ready = 1 → per_data_write_n = 10 for exactly 1 cycle, per_address = 2, per_data_in = 0x10; rsp_valid 2 cycles after acceptance, rsp_err = 0, rsp_rdata = 0.
- Read 8-bit addr 2 against a responder returning 0xDEAD_BEEF combinationally → per_data_read_n = 00 for 1 cycle; rsp_rdata = 0x0000_00EF, rsp_err = 0. Repeat with 16-bit → 0x0000_BEEF.
- Read 32-bit against a responder that never asserts data_ready, TIMEOUT = 16 → strobe active 16 cycles then 11; rsp_err = 1, rsp_rdata = 0. Then drive data_ready on exactly cycle 16 → rsp_rdata = full data, rsp_err = 0.
- Command with cmd_size = 11 → no strobe ever leaves 11; rsp_err = 1. Hold rsp_ready = 0 for 5 cycles → rsp_valid and data stable, cmd_ready = 0 until the handshake.
- Assert rst_n = 0 during the 3rd cycle of a stalled read → next edge: strobes = 11, rsp_valid = 0, cmd_ready = 1, no response emitted afterwards.
- per_user_interrupt rises → irq_seen = 1 two edges later; irq_clear pulsed while the level stays high → irq_seen = 0 and stays 0. Pulse irq_clear on the same cycle as a new rising edge → irq_seen = 1.
